// File: rtl/muxpar_rot_pipe_if.sv
// Handshake and status bundle for muxpar_rot_pipe.
// slave is the pipe itself; master is the side that sources beats and consumes results.
interface muxpar_rot_pipe_if #(
   parameter int BUS_SIZE  = 60,
   parameter int WORD_SIZE = 6,
   parameter int ROT_W     = 4,
   parameter int CNT_W     = 8
);
   localparam int WORD_NUM = BUS_SIZE / WORD_SIZE;

   logic                in_valid;
   logic                in_ready;
   logic [BUS_SIZE-1:0] data_in;
   logic [ROT_W-1:0]    rot_amt;
   logic                rot_dir;
   logic                out_valid;
   logic                out_ready;
   logic [BUS_SIZE-1:0] data_out;
   logic [WORD_NUM-1:0] control_out;
   logic                error_out;
   logic                err_clr;
   logic                err_sticky;
   logic [CNT_W-1:0]    err_count;

   modport slave (
      input  in_valid, data_in, rot_amt, rot_dir, out_ready, err_clr,
      output in_ready, out_valid, data_out, control_out, error_out, err_sticky, err_count
   );

   modport master (
      output in_valid, data_in, rot_amt, rot_dir, out_ready, err_clr,
      input  in_ready, out_valid, data_out, control_out, error_out, err_sticky, err_count
   );
endinterface

// File: rtl/muxpar_rot_pipe.sv
// Per-word parity check, word rotation and optional masking of a bus,
// registered behind a valid/ready stage with sticky error status and a saturating count.
module muxpar_rot_pipe #(
   parameter int BUS_SIZE   = 60,
   parameter int WORD_SIZE  = 6,
   parameter int WORD_NUM   = BUS_SIZE / WORD_SIZE,
   parameter int ROT_W      = 4,
   parameter int PARITY_ODD = 0,
   parameter int MASK_BAD   = 1,
   parameter int CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   muxpar_rot_pipe_if.slave     bus
);

   logic [WORD_NUM-1:0] good;
   logic [WORD_NUM-1:0] rot_ctl;
   logic [BUS_SIZE-1:0] rot_data;
   logic                in_ready;
   logic                accept;

   logic                out_valid_q;
   logic [BUS_SIZE-1:0] data_q;
   logic [WORD_NUM-1:0] ctl_q;
   logic                err_q;
   logic                sticky_q;
   logic [CNT_W-1:0]    cnt_q;

   always_comb begin
      good = '0;
      for (int unsigned i = 0; i < WORD_NUM; i++) begin
         good[i] = ((^bus.data_in[i*WORD_SIZE +: WORD_SIZE]) == 1'(PARITY_ODD));
      end
   end

   // Each output slot selects its source word by comparison against the loop index,
   // which keeps every select constant after unrolling.
   always_comb begin : rotate
      int unsigned k;
      int unsigned src;
      rot_ctl  = '0;
      rot_data = '0;
      k        = 32'(bus.rot_amt) % 32'(WORD_NUM);
      src      = 0;
      for (int unsigned j = 0; j < WORD_NUM; j++) begin
         if (bus.rot_dir)
            src = (j + k) % 32'(WORD_NUM);
         else
            src = (j + 32'(WORD_NUM) - k) % 32'(WORD_NUM);
         for (int unsigned i = 0; i < WORD_NUM; i++) begin
            if (i == src) begin
               rot_ctl[j] = good[i];
               if ((MASK_BAD != 0) && !good[i])
                  rot_data[j*WORD_SIZE +: WORD_SIZE] = '0;
               else
                  rot_data[j*WORD_SIZE +: WORD_SIZE] = bus.data_in[i*WORD_SIZE +: WORD_SIZE];
            end
         end
      end
   end

   assign in_ready = !out_valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         data_q      <= '0;
         ctl_q       <= '0;
         err_q       <= 1'b0;
         sticky_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         if (accept) begin
            out_valid_q <= 1'b1;
            data_q      <= rot_data;
            ctl_q       <= rot_ctl;
            err_q       <= ~&rot_ctl;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         // Clear applies first so a failing beat on the same edge counts as the first one.
         if (bus.err_clr) begin
            sticky_q <= 1'b0;
            cnt_q    <= '0;
         end
         if (accept && !(&rot_ctl)) begin
            sticky_q <= 1'b1;
            if (bus.err_clr)
               cnt_q <= CNT_W'(1);
            else if (cnt_q != '1)
               cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.data_out    = data_q;
   assign bus.control_out = ctl_q;
   assign bus.error_out   = err_q;
   assign bus.err_sticky  = sticky_q;
   assign bus.err_count   = cnt_q;

endmodule
